// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN executor: operator codes, error codes,
// ALU operand-count encodings and the controller state encoding.
package rpn_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned ERR_W = 3;

   // Operator codes presented on in_op / alu_op
   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB = 4'd1;
   localparam logic [OP_W-1:0] OP_MUL = 4'd2;
   localparam logic [OP_W-1:0] OP_DIV = 4'd3;
   localparam logic [OP_W-1:0] OP_POP = 4'd4;

   // Operand counts reported by the external ALU
   localparam logic [1:0] ARGS_NONE   = 2'd0;
   localparam logic [1:0] ARGS_POP    = 2'd1;
   localparam logic [1:0] ARGS_BINARY = 2'd2;

   // Error codes reported on err_code
   localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
   localparam logic [ERR_W-1:0] ERR_OVERFLOW   = 3'd1;
   localparam logic [ERR_W-1:0] ERR_UNDERFLOW  = 3'd2;
   localparam logic [ERR_W-1:0] ERR_UNKNOWN_OP = 3'd3;
   localparam logic [ERR_W-1:0] ERR_DIV_ZERO   = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/rpn_stack.sv
// Operand stack for the RPN executor. Pops and a push may be combined in
// one cycle (pop two, push one is the binary-operator write-back).
module rpn_stack #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop2,
   input  logic                   pop1,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           top,
   output logic [W-1:0]           next,
   output logic [$clog2(DEPTH):0] depth
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;
   logic [AW-1:0] wr_idx;

   // Occupancy after this cycle's pops and push; a push lands on the new top
   always_comb begin
      cnt_d = cnt_q;
      if (pop2) begin
         cnt_d = cnt_q - DW'(2);
      end else if (pop1) begin
         cnt_d = cnt_q - DW'(1);
      end
      if (push) begin
         cnt_d = cnt_d + DW'(1);
      end
      wr_idx = AW'(cnt_d - DW'(1));
   end

   // Occupancy counter doubles as the stack pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents above the pointer are don't-care
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= wdata;
      end
   end

   assign top   = (cnt_q >= DW'(1)) ? mem[AW'(cnt_q - DW'(1))] : '0;
   assign next  = (cnt_q >= DW'(2)) ? mem[AW'(cnt_q - DW'(2))] : '0;
   assign depth = cnt_q;

endmodule

// File: rtl/rpn_exec.sv
// RPN token executor driving an external combinational ALU.
// Optional feature macro: RPN_EXEC_DIV0_CHECK_EN rejects DIV by zero with
// err_code 4 instead of pushing the ALU's answer.
module rpn_exec
   import rpn_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_is_num,
   input  logic [W-1:0]           in_num,
   input  logic [OP_W-1:0]        in_op,
   output logic [OP_W-1:0]        alu_op,
   output logic [W-1:0]           alu_left,
   output logic [W-1:0]           alu_right,
   input  logic [W-1:0]           alu_ans,
   input  logic [1:0]             alu_arg_cnt,
   output logic                   res_valid,
   output logic [W-1:0]           res_data,
   output logic                   err_valid,
   output logic [ERR_W-1:0]       err_code,
   output logic [$clog2(DEPTH):0] depth
);

   localparam int unsigned DW = $clog2(DEPTH) + 1;

   state_t            state_q, state_d;
   logic              ready_q;
   logic              res_valid_q, res_valid_d;
   logic [W-1:0]      res_data_q, res_data_d;
   logic              err_valid_q, err_valid_d;
   logic [ERR_W-1:0]  err_code_q, err_code_d;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [1:0]        arg_cnt_q, arg_cnt_d;
   logic [W-1:0]      ans_q, ans_d;
   logic              push, pop2, pop1;
   logic [W-1:0]      wdata;
   logic              div_zero;

   // Divide-by-zero detection exists only when the check is built in
`ifdef RPN_EXEC_DIV0_CHECK_EN
   assign div_zero = (alu_op_q == OP_DIV) && (alu_right == '0);
`else
   assign div_zero = 1'b0;
`endif

   rpn_stack #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop2  (pop2),
      .pop1  (pop1),
      .wdata (wdata),
      .top   (alu_right),
      .next  (alu_left),
      .depth (depth)
   );

   // Next state, stack controls and next output values
   always_comb begin
      state_d     = state_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      alu_op_d    = alu_op_q;
      arg_cnt_d   = arg_cnt_q;
      ans_d       = ans_q;
      push        = 1'b0;
      pop2        = 1'b0;
      pop1        = 1'b0;
      wdata       = in_num;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (in_is_num) begin
                  // A full stack consumes and drops the number
                  if (depth == DW'(DEPTH)) begin
                     err_valid_d = 1'b1;
                     err_code_d  = ERR_OVERFLOW;
                  end else begin
                     push = 1'b1;
                  end
               end else begin
                  alu_op_d = in_op;
                  state_d  = ST_EXEC;
               end
            end
         end

         ST_EXEC: begin
            arg_cnt_d = alu_arg_cnt;
            ans_d     = alu_ans;
            if (DW'(alu_arg_cnt) > depth) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_UNDERFLOW;
               state_d     = ST_IDLE;
            end else if ((alu_arg_cnt != ARGS_POP) && (alu_arg_cnt != ARGS_BINARY)) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_UNKNOWN_OP;
               state_d     = ST_IDLE;
            end else if (div_zero) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_DIV_ZERO;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_WRITE;
            end
         end

         ST_WRITE: begin
            res_valid_d = 1'b1;
            state_d     = ST_IDLE;
            if (arg_cnt_q == ARGS_BINARY) begin
               pop2       = 1'b1;
               push       = 1'b1;
               wdata      = ans_q;
               res_data_d = ans_q;
            end else begin
               pop1       = 1'b1;
               res_data_d = alu_right;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b1;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         alu_op_q    <= '0;
         arg_cnt_q   <= ARGS_NONE;
         ans_q       <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= (state_d == ST_IDLE);
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         alu_op_q    <= alu_op_d;
         arg_cnt_q   <= arg_cnt_d;
         ans_q       <= ans_d;
      end
   end

   assign in_ready  = ready_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_rpn_exec.sv
// Testbench for rpn_exec: directed scenarios followed by random token
// streams, checked against a queue-based model of the RPN machine.
module tb_rpn_exec;
   import rpn_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned W     = 16;
   localparam int unsigned DW    = $clog2(DEPTH) + 1;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic                in_is_num;
   logic [W-1:0]        in_num;
   logic [3:0]          in_op;
   logic [3:0]          alu_op;
   logic [W-1:0]        alu_left;
   logic [W-1:0]        alu_right;
   logic [W-1:0]        alu_ans;
   logic [1:0]          alu_arg_cnt;
   logic                res_valid;
   logic [W-1:0]        res_data;
   logic                err_valid;
   logic [2:0]          err_code;
   logic [DW-1:0]       depth;

   int checks = 0;
   int errors = 0;
   int unsigned stk[$];
   int unsigned last_err = 0;

   rpn_exec #(.DEPTH(DEPTH), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_is_num   (in_is_num),
      .in_num      (in_num),
      .in_op       (in_op),
      .alu_op      (alu_op),
      .alu_left    (alu_left),
      .alu_right   (alu_right),
      .alu_ans     (alu_ans),
      .alu_arg_cnt (alu_arg_cnt),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .err_valid   (err_valid),
      .err_code    (err_code),
      .depth       (depth)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External combinational ALU; DIV by zero answers all ones
   always_comb begin
      alu_ans     = '0;
      alu_arg_cnt = 2'd0;
      case (alu_op)
         OP_ADD: begin alu_arg_cnt = 2'd2; alu_ans = alu_left + alu_right; end
         OP_SUB: begin alu_arg_cnt = 2'd2; alu_ans = alu_left - alu_right; end
         OP_MUL: begin alu_arg_cnt = 2'd2; alu_ans = alu_left * alu_right; end
         OP_DIV: begin
            alu_arg_cnt = 2'd2;
            alu_ans     = (alu_right == '0) ? '1 : alu_left / alu_right;
         end
         OP_POP: alu_arg_cnt = 2'd1;
         default: ;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stack view while idle: occupancy and the two operand taps
   task automatic check_view(input string tag);
      int n;
      n = stk.size();
      check({tag, "_depth"}, 32'(depth), 32'(n));
      check({tag, "_right"}, 32'(alu_right), (n >= 1) ? stk[n-1] : 32'd0);
      check({tag, "_left"},  32'(alu_left),  (n >= 2) ? stk[n-2] : 32'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", 32'(in_ready), 32'd1);
   endtask

   task automatic send_num(input logic [W-1:0] v);
      wait_ready();
      in_valid  = 1'b1;
      in_is_num = 1'b1;
      in_num    = v;
      in_op     = 4'($urandom);
      tick();
      in_valid  = 1'b0;
      in_is_num = 1'($urandom);
      in_num    = W'($urandom);
      if (stk.size() == DEPTH) begin
         last_err = 1;
         check("num_err_valid", 32'(err_valid), 32'd1);
      end else begin
         stk.push_back(32'(v));
         check("num_err_valid", 32'(err_valid), 32'd0);
      end
      check("num_err_code", 32'(err_code), last_err);
      check("num_res_valid", 32'(res_valid), 32'd0);
      check("num_ready", 32'(in_ready), 32'd1);
      check_view("num");
   endtask

   task automatic send_op(input logic [3:0] op);
      int argc;
      int unsigned e, l, r, expv;
      wait_ready();
      in_valid  = 1'b1;
      in_is_num = 1'b0;
      in_op     = op;
      in_num    = W'($urandom);
      tick();
      in_valid  = 1'b0;
      in_op     = 4'($urandom);
      check("exec_ready", 32'(in_ready), 32'd0);
      check("exec_alu_op", 32'(alu_op), 32'(op));
      check("exec_res_valid", 32'(res_valid), 32'd0);
      check("exec_err_valid", 32'(err_valid), 32'd0);
      argc = (op <= 4'd3) ? 2 : (op == 4'd4) ? 1 : 0;
      e = 0;
      if (argc > stk.size()) e = 2;
      else if (argc == 0) e = 3;
`ifdef RPN_EXEC_DIV0_CHECK_EN
      else if (op == OP_DIV && stk[stk.size()-1] == 0) e = 4;
`endif
      tick();
      if (e != 0) begin
         last_err = e;
         check("err_valid", 32'(err_valid), 32'd1);
         check("err_code", 32'(err_code), e);
         check("err_res_valid", 32'(res_valid), 32'd0);
         check("err_ready", 32'(in_ready), 32'd1);
         check_view("err");
      end else begin
         check("write_ready", 32'(in_ready), 32'd0);
         check("write_res_valid", 32'(res_valid), 32'd0);
         check("write_err_valid", 32'(err_valid), 32'd0);
         if (argc == 2) begin
            r = stk.pop_back();
            l = stk.pop_back();
            case (op)
               4'd0:    expv = (l + r) & 32'hFFFF;
               4'd1:    expv = (l - r) & 32'hFFFF;
               4'd2:    expv = (l * r) & 32'hFFFF;
               default: expv = (r == 0) ? 32'hFFFF : l / r;
            endcase
            stk.push_back(expv);
         end else begin
            expv = stk.pop_back();
         end
         tick();
         check("res_valid", 32'(res_valid), 32'd1);
         check("res_data", 32'(res_data), expv);
         check("res_ready", 32'(in_ready), 32'd1);
         check("res_err_valid", 32'(err_valid), 32'd0);
         check("res_err_code", 32'(err_code), last_err);
         check_view("res");
      end
      tick();
      check("pulse_res_valid", 32'(res_valid), 32'd0);
      check("pulse_err_valid", 32'(err_valid), 32'd0);
   endtask

   task automatic drain();
      while (stk.size() > 0) send_op(OP_POP);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_is_num = 1'b0;
      in_num    = '0;
      in_op     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      // State straight out of reset
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_err_valid", 32'(err_valid), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check_view("rst");

      // Tokens presented without in_valid are ignored
      for (int i = 0; i < 4; i++) begin
         in_is_num = 1'($urandom);
         in_num    = W'($urandom);
         in_op     = 4'($urandom);
         tick();
         check("novalid_res_valid", 32'(res_valid), 32'd0);
         check("novalid_err_valid", 32'(err_valid), 32'd0);
         check_view("novalid");
      end

      // Operator on empty stack underflows; POP returns the popped value
      send_op(OP_ADD);
      check("underflow_code", 32'(err_code), 32'd2);
      check("underflow_depth", 32'(depth), 32'd0);
      send_num(16'd7);
      send_op(OP_POP);
      check("pop_data", 32'(res_data), 32'd7);
      check("pop_depth", 32'(depth), 32'd0);

      // Subtraction wraps modulo 2^16
      send_num(16'd10);
      send_num(16'd20);
      send_op(OP_SUB);
      check("sub_data", 32'(res_data), 32'd65526);
      check("sub_depth", 32'(depth), 32'd1);
      drain();

      send_num(16'd20);
      send_num(16'd10);
      send_op(OP_DIV);
      check("div_data", 32'(res_data), 32'd2);
      drain();

      // Division by zero
      send_num(16'd5);
      send_num(16'd0);
      send_op(OP_DIV);
`ifdef RPN_EXEC_DIV0_CHECK_EN
      check("div0_code", 32'(err_code), 32'd4);
      check("div0_depth", 32'(depth), 32'd2);
`else
      check("div0_data", 32'(res_data), 32'hFFFF);
      check("div0_depth", 32'(depth), 32'd1);
`endif
      drain();

      // Overflow on the push after the stack fills
      for (int i = 0; i < DEPTH + 1; i++) send_num(16'd9);
      check("ovf_code", 32'(err_code), 32'd1);
      check("ovf_depth", 32'(depth), 32'(DEPTH));
      drain();

      // Unknown operator leaves the stack alone
      send_num(16'd10);
      send_num(16'd20);
      send_op(4'hF);
      check("unknown_code", 32'(err_code), 32'd3);
      check("unknown_depth", 32'(depth), 32'd2);

      // Reset while a MUL is in EXEC discards it silently
      send_num(16'd3);
      send_num(16'd4);
      wait_ready();
      in_valid  = 1'b1;
      in_is_num = 1'b0;
      in_op     = OP_MUL;
      tick();
      in_valid = 1'b0;
      check("mid_exec_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      stk.delete();
      last_err = 0;
      check("mid_rst_depth", 32'(depth), 32'd0);
      check("mid_rst_err_code", 32'(err_code), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_rst_res_valid", 32'(res_valid), 32'd0);
         check("mid_rst_err_valid", 32'(err_valid), 32'd0);
         check_view("mid_rst");
      end

      // Random token stream
      for (int i = 0; i < 300; i++) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 50) begin
            if ($urandom_range(0, 5) == 0) send_num(16'd0);
            else send_num(W'($urandom));
         end else if (sel < 88) begin
            send_op(4'($urandom_range(0, 4)));
         end else if (sel < 94) begin
            send_op(4'($urandom_range(5, 15)));
         end else begin
            in_is_num = 1'($urandom);
            in_num    = W'($urandom);
            in_op     = 4'($urandom);
            tick();
            check("rand_idle_res_valid", 32'(res_valid), 32'd0);
            check_view("rand_idle");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rpn_exec.md
RPN_EXEC -- requirements
Module: rpn_exec

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the operand stack depth in 16-bit entries (power of two, 2..64).
REQ-002 The block SHALL have parameter W, default 16, giving the data width, which matches the ALU operand width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  token present on in_is_num/in_num/in_op.
REQ-007 in_ready  out  1  block accepts a token this cycle.
REQ-008 in_is_num  in  1  1 = number token, 0 = operator token.
REQ-009 in_num  in  W  number token value.
REQ-010 in_op  in  4  operator code (ADD=0, SUB=1, MUL=2, DIV=3, POP=4, others unknown).
REQ-011 alu_op  out  4  operator driven to the external combinational ALU.
REQ-012 alu_left  out  W  second-from-top stack entry.
REQ-013 alu_right  out  W  top stack entry.
REQ-014 alu_ans  in  W  ALU result.
REQ-015 alu_arg_cnt  in  2  operand count the ALU reports for alu_op (2 arith, 1 POP, 0 unknown).
REQ-016 res_valid  out  1  one-cycle pulse: operator completed.
REQ-017 res_data  out  W  pushed result, or the popped value for POP.
REQ-018 err_valid  out  1  one-cycle pulse: token rejected.
REQ-019 err_code  out  3  1 overflow, 2 underflow, 3 unknown op, 4 divide by zero.
REQ-020 depth  out  clog2(DEPTH)+1  current stack occupancy.

Function
REQ-021 The FSM SHALL have states IDLE, EXEC and WRITE, and in_ready SHALL be high only in IDLE.
REQ-022 A number token accepted in IDLE SHALL be pushed at that edge, the FSM SHALL stay in IDLE, and depth SHALL increment.
REQ-023 A number token arriving while depth==DEPTH SHALL be dropped, with the stack unchanged and err_valid pulsed next cycle with code 1.
REQ-024 An operator token accepted in IDLE SHALL latch in_op into alu_op and move the FSM to EXEC.
REQ-025 In EXEC the block SHALL sample alu_arg_cnt and alu_ans.
- If arg_cnt exceeds depth: the stack is unchanged and err code 2 is raised.
- If arg_cnt==0: err code 3 is raised.
- Otherwise the FSM moves to WRITE.
REQ-026 In WRITE with arg_cnt==2, the block SHALL pop two entries, push alu_ans and decrement depth by 1.
REQ-027 In WRITE with arg_cnt==1, the block SHALL pop one entry, set res_data to the popped value and decrement depth by 1.
REQ-028 res_valid SHALL pulse in the WRITE cycle, and the FSM SHALL return to IDLE, giving 3-cycle operator latency from acceptance to the next in_ready.
REQ-029 Error paths SHALL return from EXEC to IDLE, pulsing err_valid for one cycle with err_code held until the next error.
REQ-030 Arithmetic results SHALL be taken from alu_ans unmodified, truncated to W bits, with no saturation.
REQ-031 alu_left and alu_right SHALL read as 0 when fewer than 2 and 1 entries are present, respectively.
REQ-032 An in_valid deasserted without acceptance SHALL have no effect.

Reset
REQ-033 On rst the block SHALL enter IDLE and empty the stack.
- depth, res_valid, res_data, err_valid, err_code, alu_op and the stack pointer are all cleared to 0.
- Reset mid-operation discards the in-flight operator with no pulse.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-035 With RPN_EXEC_DIV0_CHECK_EN defined, a DIV with alu_right==0 in EXEC SHALL raise err code 4 and leave the stack unchanged.
REQ-036 Without RPN_EXEC_DIV0_CHECK_EN, a DIV with alu_right==0 SHALL push alu_ans as returned, and err code 4 SHALL never occur.

Structure
REQ-037 Op codes, FSM state encoding and err_code values SHALL live in shared package rpn_pkg.
REQ-038 Storage SHALL be sub-module rpn_stack.
- Ports: push, pop2, pop1, wdata, top, next, depth.
- Single-cycle operation, parameterised by DEPTH and W.

Verification
REQ-039 Push 10, push 20, op SUB -> res_data=65526 (10-20 mod 2^16), depth 1, res_valid 3 cycles after op acceptance.
REQ-040 Push 20, push 10, DIV -> res_data=2.
- With RPN_EXEC_DIV0_CHECK_EN: push 5, push 0, DIV -> err_code 4, depth stays 2.
REQ-041 Push 9 DEPTH+1 times -> the last push raises err_code 1, and depth stays DEPTH.
REQ-042 Empty stack, op ADD -> err_code 2, depth 0.
- Push 7, POP -> res_data=7, depth 0.
REQ-043 Push 10, push 20, op 0xF -> err_code 3, depth 2.
- rst asserted in EXEC during MUL -> depth 0, no res_valid, in_ready 1 after release.
